// File: rtl/phase_measure_pkg.sv
// Shared definitions for the PPS interval measurement block and its PID consumer.
package phase_measure_pkg;

  // Default width of the interval counter and of Measure_Phase.
  localparam int unsigned CNT_W_DEFAULT = 24;

  // Nominal CLK_SYS cycles per PPS period, used by the downstream PID loop.
  localparam int unsigned NOMINAL_CYCLES = 1_000_000;

  // Measurement state machine.
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOST = 2'd2
  } state_e;

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer for the asynchronous PPS input plus a third stage
// used for rising-edge detection; edge_pulse is high for one cycle per edge.
module pps_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pps_async,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Next-state of the shift chain.
  always_comb begin
    s1_d = pps_async;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer and delay stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Rising edge: synchronized level is high, delayed copy still low.
  always_comb begin
    edge_pulse = s2_q & ~s3_q;
  end

endmodule

// File: rtl/phase_measure.sv
// Measures the CLK_SYS cycle count between consecutive accepted GPS PPS edges
// and flags loss of the reference after TIMEOUT_CYCLES without an edge.
// Optional feature: define PPS_HOLDOFF_EN to ignore edges arriving less than
// HOLDOFF_CYCLES after the previous accepted edge.
module phase_measure
  import phase_measure_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned HOLDOFF_CYCLES = 500_000
) (
  input  logic             CLK_SYS,
  input  logic             CLK_RST,
  input  logic             GPS_PPS,
  output logic [CNT_W-1:0] Measure_Phase,
  output logic             Measure_Done,
  output logic             Pps_Lost
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             done_q, done_d;
  logic             lost_q, lost_d;

  logic             pps_edge;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             holdoff_ok;

  pps_sync_edge u_sync (
    .clk        (CLK_SYS),
    .rst        (CLK_RST),
    .pps_async  (GPS_PPS),
    .edge_pulse (pps_edge)
  );

  // cnt_inc is the elapsed cycle count including the current cycle, so an
  // edge seen here reports exactly the edge-to-edge spacing; saturates at all ones.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    timeout = 32'(cnt_inc) >= TIMEOUT_CYCLES;
  end

  // Holdoff qualification of detected edges.
`ifdef PPS_HOLDOFF_EN
  always_comb begin
    holdoff_ok = 32'(cnt_inc) >= HOLDOFF_CYCLES;
  end
`else
  always_comb begin
    holdoff_ok = 1'b1;
  end
`endif

  // Measurement state machine and output next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    lost_d  = lost_q;
    unique case (state_q)
      ST_ARM, ST_LOST: begin
        lost_d = 1'b1;
        cnt_d  = '0;
        if (pps_edge) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // Edge takes priority over a coinciding timeout.
        if (pps_edge && holdoff_ok) begin
          phase_d = cnt_inc;
          cnt_d   = '0;
          done_d  = 1'b1;
          lost_d  = 1'b0;
        end else if (timeout) begin
          state_d = ST_LOST;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
        lost_d  = 1'b1;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    Measure_Phase = phase_q;
    Measure_Done  = done_q;
    Pps_Lost      = lost_q;
  end

endmodule

// File: tb/tb_phase_measure.sv
// Bench for phase_measure: directed vector table, hand-written reset sequence,
// then randomized PPS spacing checked against an interval-level model.
module tb_phase_measure;

  localparam int unsigned TMO  = 150;
  localparam int unsigned HOLD = 50;
`ifdef PPS_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps = 1'b0;
  logic [23:0] phase;
  logic        done, lost;
  logic [5:0]  sat_phase;
  logic        sat_done, sat_lost;

  always #5 clk = ~clk;

  phase_measure #(.CNT_W(24), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) dut (
    .CLK_SYS       (clk),
    .CLK_RST       (rst),
    .GPS_PPS       (pps),
    .Measure_Phase (phase),
    .Measure_Done  (done),
    .Pps_Lost      (lost)
  );

  // Narrow counter instance: saturates at 63 long before the timeout.
  phase_measure #(.CNT_W(6), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) dut_sat (
    .CLK_SYS       (clk),
    .CLK_RST       (rst),
    .GPS_PPS       (pps),
    .Measure_Phase (sat_phase),
    .Measure_Done  (sat_done),
    .Pps_Lost      (sat_lost)
  );

  typedef struct {
    int gap;        // cycles since previous pulse (or virtual mark)
    bit real_edge;  // 0: no pulse, just observe at the would-be strobe time
    bit exp_done;
    int exp_phase;
    bit exp_lost;
    int exp_sat;    // expected narrow-instance phase, -1 to skip
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise = 0;
  int n_strobe_seen = 0;
  int n_strobe_exp = 0;
  bit prev_lost = 1'b1;

  // Count every cycle the strobe is high, to catch spurious strobes.
  always @(negedge clk) if (done === 1'b1) n_strobe_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
  endtask

  // Pulse rises 1 ns after posedge 'c'; strobe expected after posedge c+3.
  task automatic step(input int gap, input bit real_edge, input bit exp_done,
                      input int exp_phase, input bit exp_lost, input int exp_sat);
    int target;
    target = last_rise + gap;
    while (cyc < target) tick();
    #1;
    if (real_edge) pps = 1'b1;
    last_rise = cyc;
    tick();
    tick();
    @(negedge clk);
    check("done_early", done, 1'b0);
    check("lost_pre", lost, prev_lost);
    tick();
    @(negedge clk);
    check("done", done, exp_done);
    check("lost", lost, exp_lost);
    if (exp_done) begin
      check("phase", phase, exp_phase);
      n_strobe_exp++;
    end
    if (exp_sat >= 0) check("sat_phase", sat_phase, exp_sat);
    tick();
    #1 pps = 1'b0;
    @(negedge clk);
    check("done_width", done, 1'b0);
    if (exp_done) check("phase_hold", phase, exp_phase);
    prev_lost = exp_lost;
  endtask

  vec_t tbl[10];

  bit mtrack, mlost, ed, pre_lost;
  int mlast, gap, now, elapsed, ep;

  initial begin
    tbl[0] = '{10,  1'b1, 1'b0, 0,   1'b1, -1};  // ARM: first edge, no strobe
    tbl[1] = '{100, 1'b1, 1'b1, 100, 1'b0, 63};  // strobe, lost 1->0
    tbl[2] = '{100, 1'b1, 1'b1, 100, 1'b0, 63};
    tbl[3] = '{150, 1'b1, 1'b1, 150, 1'b0, 63};  // edge coincides with timeout
    tbl[4] = '{150, 1'b0, 1'b0, 0,   1'b1, -1};  // timeout, no strobe
    tbl[5] = '{30,  1'b1, 1'b0, 0,   1'b1, -1};  // LOST: first edge rearms
    tbl[6] = '{80,  1'b1, 1'b1, 80,  1'b0, -1};
    tbl[7] = '{20,  1'b1, !HOLD_EN, 20, 1'b0, -1};  // glitch
    tbl[8] = '{80,  1'b1, 1'b1, HOLD_EN ? 100 : 80, 1'b0, -1};
    tbl[9] = '{100, 1'b1, 1'b1, 100, 1'b0, -1};

    // Power-on reset.
    repeat (3) tick();
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_done", done, 1'b0);
    check("rst_lost", lost, 1'b1);
    last_rise = cyc;
    prev_lost = 1'b1;

    for (int unsigned i = 0; i < 10; i++)
      step(tbl[i].gap, tbl[i].real_edge, tbl[i].exp_done, tbl[i].exp_phase,
           tbl[i].exp_lost, tbl[i].exp_sat);

    // Reset 40 cycles into an interval abandons the count.
    while (cyc < last_rise + 40) tick();
    #1 rst = 1'b1;
    tick();
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_phase", phase, 0);
    check("midrst_done", done, 1'b0);
    check("midrst_lost", lost, 1'b1);
    prev_lost = 1'b1;
    last_rise = cyc;
    step(20, 1'b1, 1'b0, 0, 1'b1, -1);
    step(100, 1'b1, 1'b1, 100, 1'b0, -1);

    // Randomized spacing against an interval-level model.
    mtrack = 1'b1;
    mlost  = 1'b0;
    mlast  = last_rise;
    for (int unsigned k = 0; k < 40; k++) begin
      gap     = int'($urandom_range(200, 20));
      now     = last_rise + gap;
      elapsed = now - mlast;
      if (mtrack && elapsed > int'(TMO)) begin
        mtrack = 1'b0;
        mlost  = 1'b1;
      end
      pre_lost = mlost;
      ed = 1'b0;
      ep = 0;
      if (!mtrack) begin
        mtrack = 1'b1;
        mlast  = now;
      end else if (!(HOLD_EN && elapsed < int'(HOLD))) begin
        ed    = 1'b1;
        ep    = elapsed;
        mlost = 1'b0;
        mlast = now;
      end
      prev_lost = pre_lost;
      step(gap, 1'b1, ed, ep, mlost, -1);
    end

    check("strobe_count", n_strobe_seen, n_strobe_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
